// File: rtl/apb_access_sequencer.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// optional ACCESS-phase timeout, and a one-cycle done/rdata/err report.
module apb_access_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [1:0]            req,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [1:0]            req_write,
  input  logic [63:0]           req_wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic                  busy,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [31:0]           PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [31:0]           PRDATA
);

  // state   | meaning
  // IDLE    | no transfer; grant a requester if any req is high
  // SETUP   | PSEL=1, PENABLE=0 for one cycle
  // ACCESS  | PSEL=1, PENABLE=1 until PREADY or timeout
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  localparam bit         TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT_CYC - 1) : 8'd0;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [7:0]          tmo_q, tmo_d;
  logic [1:0]          done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          gnt_c;
  logic                grant_id;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    tmo_d    = tmo_q;
    done_d   = 2'b00;
    rdata_d  = 32'd0;
    err_d    = 1'b0;
    gnt_c    = 2'b00;
    grant_id = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Contention goes to whoever was not served last.
          grant_id = (req == 2'b11) ? ~last_q : req[1];
          gnt_c    = grant_id ? 2'b10 : 2'b01;
          id_d     = grant_id;
          last_d   = grant_id;
          paddr_d  = grant_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwrite_d = req_write[grant_id];
          pwdata_d = grant_id ? req_wdata[63:32] : req_wdata[31:0];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        tmo_d   = 8'd0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        tmo_d = tmo_q + 8'd1;
        if (PREADY) begin
          state_d = S_IDLE;
          done_d  = id_q ? 2'b10 : 2'b01;
          err_d   = PSLVERR;
          rdata_d = pwrite_q ? 32'd0 : PRDATA;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          state_d = S_IDLE;
          done_d  = id_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= 32'd0;
      tmo_q    <= 8'd0;
      done_q   <= 2'b00;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      tmo_q    <= tmo_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // gnt is a same-cycle pulse; masking with PRESETn keeps it quiet while in reset.
  assign gnt     = gnt_c & {2{PRESETn}};
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign PSEL    = (state_q != S_IDLE);
  assign PENABLE = (state_q == S_ACCESS);
  assign busy    = PSEL;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule
